// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the Execute stage.
// Holds Execute with a stall while a 32-step shift-add multiply or restoring divide runs.
module ex_muldiv_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_ex_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  // state  | meaning
  // IDLE   | waiting for an M instruction in Execute
  // MUL    | shift-add multiply, one step per cycle
  // DIV    | restoring divide, one quotient bit per cycle
  // DONE   | result presented for one cycle, stall released
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  op_sel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] opnd;
  logic        neg_q;
  logic        neg_r;

  logic        is_div;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_by_zero;
  logic        div_ovf;
  logic [31:0] special_res;
  logic        accept;

  always_comb begin
    is_div      = funct3_i[2];
    a_signed    = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    b_signed    = is_div ? ~funct3_i[0] : ~funct3_i[1];
    a_neg       = a_signed & src_a_i[31];
    b_neg       = b_signed & src_b_i[31];
    a_mag       = a_neg ? (~src_a_i + 32'd1) : src_a_i;
    b_mag       = b_neg ? (~src_b_i + 32'd1) : src_b_i;
    div_by_zero = (src_b_i == 32'd0);
    div_ovf     = ~funct3_i[0] & (src_a_i == 32'h8000_0000) & (src_b_i == 32'hFFFF_FFFF);
    if (div_by_zero)
      special_res = funct3_i[1] ? src_a_i : 32'hFFFF_FFFF;
    else
      special_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    accept      = (state == S_IDLE) & start_i & ~flush_ex_i;
  end

  // Multiply step: lo holds the multiplier and shifts out as product bits shift in.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_nx;
  logic [31:0] mul_lo_nx;
  logic [63:0] prod_fix;
  logic [31:0] mul_res;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    mul_hi_nx = mul_sum[32:1];
    mul_lo_nx = {mul_sum[0], lo[31:1]};
    prod_fix  = neg_q ? (~{mul_hi_nx, mul_lo_nx} + 64'd1) : {mul_hi_nx, mul_lo_nx};
    mul_res   = (op_sel == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [31:0] div_hi_nx;
  logic [31:0] div_lo_nx;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] div_res;

  always_comb begin
    div_shift = {hi, lo[31]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[32];
    div_hi_nx = div_ge ? div_diff[31:0] : div_shift[31:0];
    div_lo_nx = {lo[30:0], div_ge};
    q_fix     = neg_q ? (~div_lo_nx + 32'd1) : div_lo_nx;
    r_fix     = neg_r ? (~div_hi_nx + 32'd1) : div_hi_nx;
    div_res   = op_sel[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      op_sel   <= 2'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      opnd     <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 32'd0;
    end else if (flush_ex_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_sel <= funct3_i[1:0];
            cnt    <= 5'd31;
            hi     <= 32'd0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (!is_div) begin
              lo    <= b_mag;
              opnd  <= a_mag;
              state <= S_MUL;
            end else if (div_by_zero || div_ovf) begin
              result_o <= special_res;
              state    <= S_DONE;
            end else begin
              lo    <= a_mag;
              opnd  <= b_mag;
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          hi  <= mul_hi_nx;
          lo  <= mul_lo_nx;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            result_o <= mul_res;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          hi  <= div_hi_nx;
          lo  <= div_lo_nx;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            result_o <= div_res;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset gating keeps the stall low while reset is held even if start_i stays high.
  always_comb begin
    busy_o  = (state == S_MUL) | (state == S_DIV);
    stall_o = ~reset_i & ~flush_ex_i & (((state == S_IDLE) & start_i) | busy_o);
    done_o  = (state == S_DONE) & ~flush_ex_i;
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: hand-computed results, cycle timing, flush and reset.
module tb_ex_muldiv_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_ex_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_ctrl dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .flush_ex_i (flush_ex_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle T: present the instruction; stall must rise combinationally.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i  = 1'b1;
    funct3_i = f3;
    src_a_i  = a;
    src_b_i  = b;
    #1 chk("stall_at_issue", {31'd0, stall_o}, 32'd1);
  endtask

  // T+1..T+32 busy with operands scrambled, T+33 done, T+34 idle with result held.
  task automatic iter_done(input string tag, input logic [31:0] exp);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      src_a_i = $urandom;
      src_b_i = $urandom;
      #1 chk({tag, "_busy"}, {29'd0, busy_o, stall_o, done_o}, 32'b110);
    end
    @(negedge clk_i);
    #1 chk({tag, "_done_flags"}, {29'd0, busy_o, stall_o, done_o}, 32'b001);
    chk({tag, "_result"}, result_o, exp);
    @(negedge clk_i);
    #1 chk({tag, "_after_flags"}, {29'd0, busy_o, stall_o, done_o}, 32'b000);
    chk({tag, "_held"}, result_o, exp);
  endtask

  // Special case: done at T+1 without ever going busy.
  task automatic special_done(input string tag, input logic [31:0] exp);
    @(negedge clk_i);
    start_i = 1'b0;
    src_a_i = $urandom;
    #1 chk({tag, "_done_flags"}, {29'd0, busy_o, stall_o, done_o}, 32'b001);
    chk({tag, "_result"}, result_o, exp);
    @(negedge clk_i);
    #1 chk({tag, "_after_flags"}, {29'd0, busy_o, stall_o, done_o}, 32'b000);
  endtask

  initial begin
    reset_i    = 1'b1;
    start_i    = 1'b0;
    funct3_i   = 3'b000;
    src_a_i    = 32'd0;
    src_b_i    = 32'd0;
    flush_ex_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 chk("reset_flags", {29'd0, busy_o, stall_o, done_o}, 32'b000);
    chk("reset_result", result_o, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    issue(3'b000, 32'd7, 32'hFFFF_FFFD);            // MUL 7 * -3
    iter_done("mul", 32'hFFFF_FFEB);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    // MULHU
    iter_done("mulhu", 32'hFFFF_FFFE);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000);    // MULH
    iter_done("mulh", 32'h4000_0000);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    // MULHSU -1 * 0xFFFFFFFF
    iter_done("mulhsu", 32'hFFFF_FFFF);
    issue(3'b000, 32'h1234_5678, 32'd16);
    iter_done("mul_shift", 32'h2345_6780);

    issue(3'b100, 32'hFFFF_FFF9, 32'd2);            // DIV -7 / 2
    iter_done("div", 32'hFFFF_FFFD);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2);            // REM -7 / 2
    iter_done("rem", 32'hFFFF_FFFF);
    issue(3'b101, 32'd100, 32'd7);                  // DIVU
    iter_done("divu", 32'd14);
    issue(3'b111, 32'd100, 32'd7);                  // REMU
    iter_done("remu", 32'd2);

    // Flush a DIV at T+10; MUL issued at T+11 must finish at T+44.
    issue(3'b100, 32'd1000, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      #1 chk("flush_pre_busy", {29'd0, busy_o, stall_o, done_o}, 32'b110);
    end
    @(negedge clk_i);
    flush_ex_i = 1'b1;
    #1 chk("flush_cycle", {29'd0, busy_o, stall_o, done_o}, 32'b100);
    @(negedge clk_i);
    flush_ex_i = 1'b0;
    #1 chk("flush_idle", {30'd0, busy_o, done_o}, 32'd0);
    chk("flush_result_kept", result_o, 32'd2);
    issue(3'b000, 32'd6, 32'd7);
    iter_done("flush_mul", 32'd42);

    issue(3'b100, 32'd5, 32'd0);                    // DIV 5 / 0
    special_done("div0", 32'hFFFF_FFFF);
    issue(3'b111, 32'd5, 32'd0);                    // REMU 5 / 0
    special_done("remu0", 32'd5);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);    // DIV overflow
    special_done("div_ovf", 32'h8000_0000);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);    // REM overflow
    special_done("rem_ovf", 32'd0);

    // Reset at T+5 of a MUL while start stays high, then a fresh operation.
    issue(3'b000, 32'd3, 32'd5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    @(negedge clk_i);
    reset_i  = 1'b1;
    start_i  = 1'b1;
    funct3_i = 3'b000;
    src_a_i  = 32'd9;
    src_b_i  = 32'd11;
    #1 chk("midrst_flags", {29'd0, busy_o, stall_o, done_o}, 32'b000);
    chk("midrst_result", result_o, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1 chk("postrst_stall", {31'd0, stall_o}, 32'd1);
    iter_done("postrst_mul", 32'd99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle sequencer for RV32M multiply/divide operations issued from the Execute stage. On a qualified start it captures the forwarded Execute operands, holds the Execute stage with a stall request, and runs a 32-step shift-add multiply or restoring divide. It then presents a registered result for exactly one cycle, in which the stall is released so the instruction retires into Memory. It sits beside the ALU in the Execute stage; the hazard unit ORs `stall_o` into its Execute/Decode/Fetch stall terms.

## Interface
Parameters:
- none

Ports:
- `clk_i`  input  1  clock; one clock domain.
- `reset_i`  input  1  asynchronous, active-high reset.
- `start_i`  input  1  Execute holds a valid M-extension instruction (`valid_ex` & muldiv decode).
- `funct3_i`  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a_i`  input  32  forwarded rs1 operand (post forward mux).
- `src_b_i`  input  32  forwarded rs2 operand (post forward mux).
- `flush_ex_i`  input  1  Execute flush; cancels any operation.
- `stall_o`  output  1  stall request to the hazard unit.
- `busy_o`  output  1  FSM in MUL or DIV.
- `done_o`  output  1  result valid this cycle (one-cycle pulse).
- `result_o`  output  32  registered result.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL: `start_i` & funct3[2]=0.
  - IDLE → DIV: `start_i` & funct3[2]=1 & no special case.
  - IDLE → DONE: `start_i` & divide special case.
  - MUL/DIV → DONE: iteration count reaches 0.
  - DONE → IDLE: always.
- `start_i` is sampled only in IDLE. A `start_i` seen in DONE belongs to the retiring instruction and is ignored.
- On accept, latch funct3, the operand magnitudes, and the sign-correction flags, and load the 5-bit counter to 31.
  - MUL/MULH treat both operands as signed.
  - MULHSU treats A as signed and B as unsigned.
  - MULHU/DIVU/REMU treat both operands as unsigned.
- MUL: 64-bit accumulator with one shift-add per cycle. At completion, negate the product if the sign flag is set.
  - MUL returns bits [31:0].
  - MULH/MULHSU/MULHU return bits [63:32].
- DIV: restoring divide, one quotient bit per cycle. At completion, fix signs.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases are resolved in IDLE with no iteration:
  - Divisor = 0: DIV/DIVU return 0xFFFF_FFFF; REM/REMU return the dividend.
  - Signed overflow (0x8000_0000 / 0xFFFF_FFFF): DIV returns 0x8000_0000; REM returns 0.
- `result_o` is written on entry to DONE and holds its value otherwise.
- `stall_o` = (IDLE & `start_i`) | MUL | DIV. It is 0 in DONE.
- `flush_ex_i`:
  - In any state, next state is IDLE.
  - `done_o` is not asserted for the cancelled operation and `result_o` is unchanged.
  - `stall_o` is forced to 0 in the flush cycle.
- Reset: state IDLE; counter 0; `result_o`=0, `done_o`=0, `busy_o`=0, `stall_o`=0.

## Timing
- Cycle T: `start_i` is sampled in IDLE, operands are captured, and `stall_o`=1 (combinational from `start_i`).
- Iterative case:
  - T+1 through T+32: MUL/DIV, `busy_o`=1, `stall_o`=1.
  - T+33: DONE, `done_o`=1, `result_o` valid, `stall_o`=0.
  - Total 34 cycles from issue to retirement.
- Special case: DONE at T+1 with `done_o`=1; 2 cycles total.
- Back-to-back M instructions: the second is accepted at T+34 (IDLE), with no overlap.
- Operands must be stable only at T. Forwarding may change during the stall without effect.
- Reset mid-operation: asynchronous return to IDLE, with all outputs at reset values immediately.

## Test plan
- MUL 7 × -3 at T → `stall_o` high T..T+32; at T+33 `done_o`=1, `result_o`=0xFFFF_FFEB, `stall_o`=0.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → `result_o`=0xFFFF_FFFE. MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHSU -1 × 0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFD. REM -7 / 2 → 0xFFFF_FFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. All at T+33.
- DIV 5 / 0 → 0xFFFF_FFFF at T+1. REMU 5 / 0 → 5. DIV 0x8000_0000 / -1 → 0x8000_0000. REM → 0. `busy_o` never asserts.
- Flush at T+10 of a DIV → IDLE at T+11, no `done_o`, `result_o` keeps its prior value; a new MUL at T+11 completes at T+44.
- Assert `reset_i` at T+5 of a MUL → immediate IDLE with all outputs 0; a held `start_i` after reset deassertion starts a fresh 34-cycle operation.
